// File: rtl/spmm_tcdm_stream_source.sv
// Strided TCDM word reader feeding a credit-limited FIFO exposed as a valid/ready stream.
// Optional bounds check (zero-fill plus sticky err_o) is enabled with `define SPMM_SRC_BOUNDS_CHECK_EN.
module spmm_tcdm_stream_source #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_WORDS  = 12288
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [ADDR_W-1:0]   stride_i,
    input  logic [LEN_W-1:0]    len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                tcdm_req_o,
    input  logic                tcdm_gnt_i,
    output logic [ADDR_W-1:0]   tcdm_add_o,
    output logic                tcdm_wen_o,
    output logic [DATA_W/8-1:0] tcdm_be_o,
    input  logic                tcdm_r_valid_i,
    input  logic [DATA_W-1:0]   tcdm_r_data_i,
    output logic                stream_valid_o,
    input  logic                stream_ready_i,
    output logic [DATA_W-1:0]   stream_data_o,
    output logic                stream_last_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr, stride;
    logic [LEN_W-1:0]  len, issued, popped;
    logic [CW-1:0]     inflight, count;
    logic [PW-1:0]     wptr, rptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic active, credit, want, fill, grant, step, push_rsp, push, pop, last_pop, all_out;

    assign active   = (state == RUN) || (state == DRAIN);
    // Buffered plus outstanding never exceeds the FIFO, so every response has a slot.
    assign credit   = (SW'(count) + SW'(inflight)) < SW'(FIFO_DEPTH);
    assign want     = (state == RUN) && (issued < len) && credit;

`ifdef SPMM_SRC_BOUNDS_CHECK_EN
    logic oob, err_q;
    assign oob        = addr[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_WORDS);
    // Zero-fill only when no response can land in the same cycle (single write port).
    assign fill       = want && oob && (inflight == '0) && !tcdm_r_valid_i;
    assign tcdm_req_o = want && !oob;
    assign err_o      = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      err_q <= 1'b0;
        else if (clear_i) err_q <= 1'b0;
        else if (fill)    err_q <= 1'b1;
    end
`else
    assign fill       = 1'b0;
    assign tcdm_req_o = want;
    assign err_o      = 1'b0;
`endif

    assign grant    = tcdm_req_o && tcdm_gnt_i;
    assign step     = grant || fill;
    // Responses outside RUN/DRAIN belong to an aborted transfer and are dropped.
    assign push_rsp = active && tcdm_r_valid_i;
    assign push     = push_rsp || fill;
    assign pop      = stream_valid_o && stream_ready_i;
    assign last_pop = pop && (popped == len - LEN_W'(1));
    assign all_out  = (popped == len) || last_pop;

    assign tcdm_add_o     = addr;
    assign tcdm_wen_o     = 1'b1;
    assign tcdm_be_o      = '1;
    assign busy_o         = active;
    assign done_o         = (state == DONE);
    assign stream_valid_o = (count != '0);
    assign stream_data_o  = mem[rptr];
    assign stream_last_o  = stream_valid_o && (popped == len - LEN_W'(1));

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= fill ? '0 : tcdm_r_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE; addr <= '0; stride <= '0; len <= '0;
            issued <= '0; popped <= '0; inflight <= '0; count <= '0;
            wptr <= '0; rptr <= '0;
        end else if (clear_i) begin
            state <= IDLE; addr <= '0; stride <= '0; len <= '0;
            issued <= '0; popped <= '0; inflight <= '0; count <= '0;
            wptr <= '0; rptr <= '0;
        end else begin
            if (step) begin
                addr   <= addr + stride;
                issued <= issued + LEN_W'(1);
            end
            case ({grant, push_rsp})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push) wptr <= wptr + PW'(1);
            if (pop) begin
                rptr   <= rptr + PW'(1);
                popped <= popped + LEN_W'(1);
            end
            case (state)
                IDLE: if (start_i) begin
                    if (len_i == '0) state <= DONE;
                    else begin
                        state  <= RUN;
                        addr   <= base_addr_i & ALIGN;
                        stride <= stride_i & ALIGN;
                        len    <= len_i;
                        issued <= '0;
                        popped <= '0;
                    end
                end
                RUN:     if (issued == len) state <= all_out ? DONE : DRAIN;
                DRAIN:   if (all_out) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_rsp && (count == CW'(FIFO_DEPTH))));
endmodule

// File: doc/spmm_tcdm_stream_source.md
Name: spmm_tcdm_stream_source

Overview:
- Strided-read streamer between the shared TCDM memory (12288 32-bit words) and the SpMM datapath. Used for sparse values, indices and dense-operand rows.
- On `start_i`, issues `len_i` word reads at `base_addr_i + k*stride_i` over a req/gnt TCDM port.
- Buffers responses in a credit-limited FIFO and presents them as a valid/ready stream with a last flag.
- Drives both the outer-product and Gustavson engines; it is also the block the testbench memory model serves directly.

Parameters:
- DATA_W, 32, TCDM word and stream width in bits.
- ADDR_W, 32, byte address width.
- LEN_W, 16, width of the transfer-length field.
- FIFO_DEPTH, 4, response buffer entries; power of two, at least 2.
- MEM_WORDS, 12288, TCDM size in words; used only by the optional bounds check.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous soft clear; same effect as reset.
- start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- base_addr_i  in  ADDR_W  first byte address; must be word aligned.
- stride_i  in  ADDR_W  byte stride; two's complement, so negative strides are allowed.
- len_i  in  LEN_W  number of words to read; 0 is legal.
- busy_o  out  1  high from the cycle after an accepted start until done.
- done_o  out  1  one-cycle pulse when the last word has left the stream.
- err_o  out  1  sticky bounds error (optional feature only; tied 0 otherwise).
- tcdm_req_o  out  1  request valid.
- tcdm_gnt_i  in  1  grant; a request is transferred when req && gnt.
- tcdm_add_o  out  ADDR_W  request byte address.
- tcdm_wen_o  out  1  constant 1 (read).
- tcdm_be_o  out  DATA_W/8  constant all ones.
- tcdm_r_valid_i  in  1  response valid, exactly 1 cycle after the grant.
- tcdm_r_data_i  in  DATA_W  response data.
- stream_valid_o  out  1  output data valid.
- stream_ready_i  in  1  consumer ready.
- stream_data_o  out  DATA_W  output word (FIFO head).
- stream_last_o  out  1  high with the final word of a transfer.

Behaviour:
- Reset/clear: FSM=IDLE; address counter, request counter, pop counter, FIFO pointers and inflight counter all 0. All outputs 0 except `tcdm_wen_o`=1 and `tcdm_be_o`=all ones.
- FSM IDLE: `start_i` with `len_i`>0 latches base/stride/len and moves to RUN. `start_i` with `len_i`=0 goes to DONE directly, issuing no requests.
- FSM RUN: `tcdm_req_o`=1 when `issued < len` and `fifo_count + inflight < FIFO_DEPTH`.
  - Address and request are held stable until granted; the request is never withdrawn.
  - On grant: address += stride (wraps modulo 2^ADDR_W), issued++, inflight++.
  - Once `issued == len`, move to DRAIN.
- FSM DRAIN: no new requests; wait until `popped == len`, then go to DONE.
- FSM DONE: `done_o`=1 for exactly one cycle, then IDLE. `busy_o`=1 in RUN and DRAIN.
- Response path: `tcdm_r_valid_i` pushes `tcdm_r_data_i` into the FIFO and decrements inflight.
  - Credit accounting guarantees no overflow; an r_valid arriving with the FIFO full is a protocol violation and is covered by an assertion.
  - Push and pop in the same cycle keep the count unchanged.
  - A grant and r_valid in the same cycle leave inflight unchanged.
- Stream: `stream_valid_o` = FIFO not empty; pop on valid && ready.
  - Data and last are held stable while valid && !ready.
  - `stream_last_o` = valid && (popped == len-1).
  - Minimum latency from start to the first stream_valid is 3 cycles, with an immediate grant.
  - With gnt and ready held at 1, throughput is 1 word/cycle.
- start_i while busy: ignored.
- clear_i mid-transfer: aborts immediately. Any response arriving after the clear is discarded and no done_o is produced.
- Async reset mid-transfer: same as clear.
- Unaligned base address or stride: the low two bits are forced to 0 on the TCDM address.

Optional Feature:
- Macro: SPMM_SRC_BOUNDS_CHECK_EN.
- With the macro: before asserting req, the word index (addr>>2) is compared against MEM_WORDS.
  - If out of range, no request is issued for that word. A 0 word is pushed in its place, without TCDM traffic, so stream length is preserved.
  - `err_o` is set and stays 1 until reset or clear.
- Without the macro: `err_o` is tied 0 and there is no comparator logic.

Test Plan:
- Contiguous read: base=0x0, stride=4, len=8, gnt=1, ready=1 -> addresses 0x00..0x1C, 8 consecutive stream words, last on the 8th, done 1 cycle after the last pop, busy low the following cycle.
- Backpressure: len=16, ready toggled 1 cycle on, 3 off -> never more than 4 outstanding plus buffered, data order preserved, no FIFO overflow assertion.
- Random grant stalls: gnt 50% random, stride=0x40, len=10 -> address held stable while ungranted, addresses base+0x40*k, 10 words out in order.
- Zero length and busy start: len=0 -> done pulse with no tcdm_req. A second start_i during a len=5 transfer is ignored and exactly 5 words are emitted.
- Clear mid-run: clear_i on cycle 4 of len=12 -> next cycle req=0, valid=0, busy=0, no done. A fresh start then streams correctly.
- Bounds check (macro defined): base=12286*4, stride=4, len=4 -> 2 real reads, 2 zero words, err_o=1, still 4 stream words.
